// File: rtl/tipi_pkg.sv
// Shared types and helpers for the TIPI register read-back path:
// FSM encoding, priority encoder and multi-select detection.
package tipi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int MAX_CHANNELS = 16;

  // Channel index width; never below 1 so a port can always be declared.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set index wins (channel 0 has highest priority).
  function automatic logic [3:0] prio_enc(input logic [MAX_CHANNELS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcount_gt1(input logic [MAX_CHANNELS-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/sync_vec.sv
// N-bit, STAGES-deep flop synchroniser with asynchronous clear.
// A depth of 0 is a straight pass-through for already-synchronous inputs.
module sync_vec #(
  parameter int N      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  generate
    if (STAGES == 0) begin : g_pass
      assign q = d;
    end else begin : g_sync
      logic [N-1:0] stage [STAGES];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/rreg_mux_n.sv
// Registered read-back mux: captures the highest-priority selected channel,
// freezes it for the whole read, and pulses rd_done when that select drops.
module rreg_mux_n
  import tipi_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CHANNELS    = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_VALUE  = '0,
  localparam int              CHAN_W      = chan_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       sel,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic [WIDTH-1:0]          o,
  output logic                      valid,
  output logic                      collision,
  output logic [CHAN_W-1:0]         chan,
  output logic [CHANNELS-1:0]       rd_done
);

  logic [CHANNELS-1:0]     sel_s;
  logic [WIDTH-1:0]        lane [CHANNELS];
  logic [MAX_CHANNELS-1:0] sel_ext;
  logic [CHAN_W-1:0]       pick_idx;
  logic                    multi;
  logic                    rel_hit;
  logic [CHANNELS-1:0]     done_dec;

  state_t                  state, state_next;
  logic [WIDTH-1:0]        o_next;
  logic                    valid_next;
  logic                    collision_next;
  logic [CHAN_W-1:0]       chan_next;
  logic [CHANNELS-1:0]     rd_done_next;

  sync_vec #(
    .N      (CHANNELS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sel),
    .q     (sel_s)
  );

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      assign lane[gi]     = data[gi*WIDTH +: WIDTH];
      assign done_dec[gi] = (chan == CHAN_W'(gi));
    end
  endgenerate

  always_comb begin
    sel_ext                 = '0;
    sel_ext[CHANNELS-1:0]   = sel_s;
  end

  assign pick_idx = CHAN_W'(prio_enc(sel_ext));
  assign multi    = popcount_gt1(sel_ext);
  // Only the captured channel's select ends a read; other bits are ignored in HOLD.
  assign rel_hit  = ~sel_s[chan];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|sel_s) state_next = HOLD;
      HOLD:    if (rel_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_next         = o;
    valid_next     = valid;
    collision_next = collision;
    chan_next      = chan;
    rd_done_next   = '0;
    case (state)
      IDLE: begin
        if (|sel_s) begin
          o_next         = lane[pick_idx];
          chan_next      = pick_idx;
          valid_next     = 1'b1;
          collision_next = multi;
        end else begin
          o_next         = IDLE_VALUE;
          chan_next      = '0;
          valid_next     = 1'b0;
          collision_next = 1'b0;
        end
      end
      HOLD: begin
        if (rel_hit) begin
          rd_done_next   = done_dec;
          o_next         = IDLE_VALUE;
          chan_next      = '0;
          valid_next     = 1'b0;
          collision_next = 1'b0;
        end
      end
      default: begin
        o_next         = IDLE_VALUE;
        chan_next      = '0;
        valid_next     = 1'b0;
        collision_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o         <= IDLE_VALUE;
      valid     <= 1'b0;
      collision <= 1'b0;
      chan      <= '0;
      rd_done   <= '0;
    end else begin
      o         <= o_next;
      valid     <= valid_next;
      collision <= collision_next;
      chan      <= chan_next;
      rd_done   <= rd_done_next;
    end
  end

endmodule

// File: tb/tb_rreg_mux_n.sv
// Scoreboard bench: stimulus predicts capture/rd_done events with their cycle;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_rreg_mux_n;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sel = '0;
  logic [31:0] data = '0;
  logic [7:0]  o;
  logic        valid, collision;
  logic [1:0]  chan;
  logic [3:0]  rd_done;

  logic [5:0]  sel2 = '0;
  logic [95:0] data2 = '0;
  logic [15:0] o2;
  logic        valid2, collision2;
  logic [2:0]  chan2;
  logic [5:0]  rd_done2;

  rreg_mux_n #(.WIDTH(8), .CHANNELS(4), .SYNC_STAGES(S), .IDLE_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .sel(sel), .data(data), .o(o), .valid(valid),
    .collision(collision), .chan(chan), .rd_done(rd_done)
  );

  rreg_mux_n #(.WIDTH(16), .CHANNELS(6), .SYNC_STAGES(0), .IDLE_VALUE(16'hFFFF)) dut2 (
    .clk(clk), .reset(reset), .sel(sel2), .data(data2), .o(o2), .valid(valid2),
    .collision(collision2), .chan(chan2), .rd_done(rd_done2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] o;
    logic [1:0] chan;
    logic       coll;
    int         cyc;
  } cap_t;

  typedef struct {
    logic [3:0] v;
    int         cyc;
  } done_t;

  cap_t  capq[$];
  done_t doneq[$];
  int    done_seen = 0;

  // Monitor: every negedge either matches an event, checks a frozen read, or checks idle.
  initial begin
    logic  prev_valid;
    cap_t  cur;
    cap_t  e;
    done_t d;
    prev_valid = 1'b0;
    cur = '{8'h00, 2'd0, 1'b0, 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (rd_done != 4'b0) begin
          done_seen++;
          if (doneq.size() == 0) begin
            chk("unexpected_rd_done", 32'(rd_done), 32'h0);
          end else begin
            d = doneq.pop_front();
            chk("rd_done", 32'(rd_done), 32'(d.v));
            chk("rd_done_cycle", cyc, d.cyc);
          end
        end
        if (valid && !prev_valid) begin
          if (capq.size() == 0) begin
            chk("unexpected_capture", 32'(valid), 32'h0);
          end else begin
            e = capq.pop_front();
            chk("cap_o", 32'(o), 32'(e.o));
            chk("cap_chan", 32'(chan), 32'(e.chan));
            chk("cap_collision", 32'(collision), 32'(e.coll));
            chk("cap_cycle", cyc, e.cyc);
            cur = e;
          end
        end else if (valid) begin
          chk("hold_o", 32'(o), 32'(cur.o));
          chk("hold_chan", 32'(chan), 32'(cur.chan));
          chk("hold_collision", 32'(collision), 32'(cur.coll));
        end else begin
          chk("idle_o", 32'(o), 32'h00);
          chk("idle_chan", 32'(chan), 32'h0);
          chk("idle_collision", 32'(collision), 32'h0);
        end
        prev_valid = valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return 0;
  endfunction

  int last_done = 0;
  bit held = 1'b0;
  int held_p = 0;

  // One read: raise p with data d, swap data to d2 once captured, optionally
  // drop the non-winning bits, then release (gap>0) or leave held for a handoff.
  task automatic issue(input logic [3:0] p, input logic [31:0] d, input logic [31:0] d2,
                       input int extra, input bit drop, input int gap);
    int    k, c, lp;
    cap_t  e;
    done_t dn;
    k  = cyc;
    lp = lowest(p);
    if (held) begin
      dn.v = 4'b1 << held_p;
      dn.cyc = k + S + 1;
      doneq.push_back(dn);
      last_done = dn.cyc;
      held = 1'b0;
    end
    sel  = p;
    data = d;
    c = (k + S + 1 > last_done + 1) ? k + S + 1 : last_done + 1;
    e.o    = d[lp*8 +: 8];
    e.chan = 2'(lp);
    e.coll = ($countones(p) > 1);
    e.cyc  = c;
    capq.push_back(e);
    while (cyc < c) tick();
    data = d2;
    if (drop) begin
      sel = 4'b1 << lp;
      tick();
    end
    repeat (extra) tick();
    if (gap > 0) begin
      dn.v = 4'b1 << lp;
      dn.cyc = cyc + S + 1;
      doneq.push_back(dn);
      last_done = dn.cyc;
      sel = 4'b0;
      repeat (gap) tick();
    end else begin
      held = 1'b1;
      held_p = lp;
    end
  endtask

  initial begin
    int          k, c, ds;
    cap_t        e;
    logic [3:0]  p;
    logic [5:0]  lowmask, extra2;
    logic [15:0] exp16;
    logic [31:0] rd;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_o", 32'(o), 32'h00);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_rd_done", 32'(rd_done), 32'h0);
    chk("reset_o2", 32'(o2), 32'hFFFF);
    tick();
    reset = 1'b0;

    // Reset while channel 2 is held.
    k = cyc;
    sel = 4'b0100;
    data = $urandom();
    c = k + S + 1;
    e.o = data[23:16]; e.chan = 2'd2; e.coll = 1'b0; e.cyc = c;
    capq.push_back(e);
    while (cyc < c + 1) tick();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_o", 32'(o), 32'h00);
    chk("async_reset_valid", 32'(valid), 32'h0);
    chk("async_reset_chan", 32'(chan), 32'h0);
    sel = 4'b0;
    ds = done_seen;
    tick();
    tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("no_done_after_reset", done_seen, ds);
    last_done = cyc;

    issue(4'b0010, 32'h0000_A500, 32'h0000_A500, 3, 1'b0, 4);
    issue(4'b0001, 32'h0000_0011, 32'h0000_0022, 4, 1'b0, 3);
    issue(4'b1010, 32'hC300_3C00, 32'hC300_3C00, 2, 1'b1, 3);
    issue(4'b0001, $urandom(), $urandom(), 2, 1'b0, 0);
    issue(4'b0100, $urandom(), $urandom(), 2, 1'b0, 3);

    for (int n = 0; n < 150; n++) begin
      p = 4'($urandom_range(1, 15));
      if (held) begin
        p = p & ~(4'b1 << held_p);
        if (p == 4'b0) p = 4'b1 << ((held_p + 1) % 4);
      end
      issue(p, $urandom(), $urandom(), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
            (n == 149) ? 3 : $urandom_range(0, 3));
    end
    repeat (S + 4) tick();
    chk("capq_drained", capq.size(), 0);
    chk("doneq_drained", doneq.size(), 0);

    // Wide, unsynchronised instance: 1-cycle latency and 0xFFFF idle value.
    chk("p_idle_o", 32'(o2), 32'hFFFF);
    for (int ch = 0; ch < 6; ch++) begin
      @(negedge clk);
      data2 = {$urandom(), $urandom(), $urandom()};
      lowmask = 6'((1 << (ch + 1)) - 1);
      extra2 = 6'($urandom()) & ~lowmask;
      sel2 = 6'(1 << ch) | extra2;
      exp16 = data2[ch*16 +: 16];
      @(negedge clk);
      chk("p_valid", 32'(valid2), 32'h1);
      chk("p_o", 32'(o2), 32'(exp16));
      chk("p_chan", 32'(chan2), ch);
      chk("p_collision", 32'(collision2), 32'(extra2 != 6'b0));
      rd = $urandom();
      data2[ch*16 +: 16] = rd[15:0];
      @(negedge clk);
      chk("p_hold_o", 32'(o2), 32'(exp16));
      sel2 = 6'b0;
      @(negedge clk);
      chk("p_rd_done", 32'(rd_done2), 32'(1 << ch));
      chk("p_release_o", 32'(o2), 32'hFFFF);
      chk("p_release_valid", 32'(valid2), 32'h0);
      @(negedge clk);
      chk("p_rd_done_once", 32'(rd_done2), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/rreg_mux_n.md
# rreg_mux_n

Parametrised registered read-back multiplexer for the TIPI CPLD register file. It selects one of `CHANNELS` register values onto the TI-side read data path using priority-ordered select lines. Unlike the fixed 4×8 free-running mux, it synchronises the selects, freezes the captured value for the whole read cycle, flags multi-select collisions, and emits a per-channel read-done pulse. Clear-on-read logic uses that pulse, for example to drop a Pi-to-TI "data available" flag.

## Interface
- `WIDTH`, 8: data width of each channel and of the output.
- `CHANNELS`, 4: number of selectable registers, 2..16; index 0 has highest priority.
- `SYNC_STAGES`, 2: flops on `sel` before use, 0..3; 0 means `sel` is already synchronous.
- `IDLE_VALUE`, 0: value driven on `o` when no read is in progress.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `sel`  in  CHANNELS  per-channel read select, level-sensitive, possibly asynchronous.
- `data`  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `o`  out  WIDTH  registered read data.
- `valid`  out  1  high while `o` holds a captured channel value.
- `collision`  out  1  sticky for the current read: more than one `sel_s` bit was set at capture.
- `chan`  out  clog2(CHANNELS)  index of the captured channel; 0 when idle.
- `rd_done`  out  CHANNELS  one-cycle pulse on the captured channel's bit when its read ends.

## Operation
- `sel_s` is `sel` after `SYNC_STAGES` flops. All decisions use `sel_s` only.
- The FSM has two states, IDLE and HOLD.
- IDLE, with `sel_s` == 0: `o` = `IDLE_VALUE`, `valid` = 0, `collision` = 0, `chan` = 0.
- IDLE, with `sel_s` != 0:
  - capture p = lowest set index of `sel_s`;
  - `o` <= data[p], `chan` <= p, `valid` <= 1;
  - `collision` <= (popcount(`sel_s`) > 1);
  - go to HOLD.
- HOLD: `o`, `chan` and `collision` are frozen. Changes on `data` or on other `sel_s` bits are ignored.
- HOLD, with `sel_s[chan]` == 0:
  - `rd_done[chan]` pulses for exactly one cycle;
  - `o` <= `IDLE_VALUE`, `valid` <= 0, `collision` <= 0, `chan` <= 0;
  - go to IDLE.
- A select that hands directly from one channel to another therefore produces:
  - the `rd_done` pulse for the old channel;
  - one IDLE cycle;
  - the capture of the new channel on the following cycle.
- `rd_done` is never asserted for a channel that was not captured, and never more than once per capture.
- Reset, including mid-read: state = IDLE, synchroniser flops = 0, `o` = `IDLE_VALUE`, `valid` = 0, `collision` = 0, `chan` = 0, `rd_done` = 0. No `rd_done` is issued for a read interrupted by reset.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `sel` rise to `valid` or `o` update: `SYNC_STAGES` + 1 cycles.
- `sel` fall to `rd_done` pulse: `SYNC_STAGES` + 1 cycles. `o` returns to `IDLE_VALUE` on the same edge as the pulse.
- The captured `data` is the value present on the clock edge at which `sel_s` first becomes non-zero in IDLE.
- A select pulse shorter than one `clk` period after synchronisation may be missed. This is accepted; bus reads are several cycles long.
- Minimum spacing between two captures: 2 cycles (one HOLD cycle, one IDLE cycle).

## Structure
- Shared package `tipi_pkg`:
  - state encoding type (IDLE, HOLD);
  - `prio_enc` function (lowest set index);
  - `popcount_gt1` function;
  - `CHAN_W` = clog2(CHANNELS) helper.
- Sub-module `sync_vec`: a parametrised `SYNC_STAGES`-deep, N-bit flop synchroniser with asynchronous reset to 0. At depth 0 it is a pass-through.
- Top level: FSM, capture register, and `rd_done` decode.

## Test plan
- Reset mid-HOLD: apply `reset` while channel 2 is captured. Required: `o` = `IDLE_VALUE`, `valid` = 0 and `chan` = 0 immediately (asynchronous); no `rd_done` pulse afterwards.
- Single read with defaults:
  - stimulus: `data` ch1 = 0xA5; `sel` = 0010 for 6 cycles, then 0000;
  - required: `o` = 0xA5 with `valid` = 1 from cycle 3;
  - required: `rd_done` = 0010 for one cycle at release + 3;
  - required: `o` returns to 0x00.
- Hold stability: capture ch0 = 0x11, then change ch0 data to 0x22 while `sel` is held. Required: `o` stays 0x11 until release.
- Collision:
  - stimulus: `sel` = 1010 with ch1 = 0x3C and ch3 = 0xC3;
  - required: `o` = 0x3C, `chan` = 1, `collision` = 1;
  - required: releasing bit 3 alone changes nothing; releasing bit 1 pulses `rd_done` = 0010.
- Handoff:
  - stimulus: `sel` switches 0001 → 0100 in one edge;
  - required: `rd_done` = 0001, then one cycle with `valid` = 0, then `o` = data[2] with `chan` = 2.
- Parametrisation: `WIDTH` = 16, `CHANNELS` = 6, `SYNC_STAGES` = 0, `IDLE_VALUE` = 16'hFFFF. Required: capture latency is 1 cycle, and the idle output is 0xFFFF.
